// File: rtl/iob_cpu_bus_split.sv
// Bridges a PicoRV32-style valid/ready memory port onto separate IOb instruction and data buses.
// One request is outstanding at a time; a response timeout completes hung requests and raises a sticky error.
module iob_cpu_bus_split #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT_W = 8,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                cpu_valid_i,
    input  logic                cpu_instr_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic [DATA_W/8-1:0] cpu_wstrb_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_ready_o,
    output logic                ibus_avalid_o,
    output logic [ADDR_W-1:0]   ibus_addr_o,
    input  logic                ibus_aready_i,
    input  logic [DATA_W-1:0]   ibus_rdata_i,
    input  logic                ibus_rvalid_i,
    output logic                dbus_avalid_o,
    output logic [ADDR_W-1:0]   dbus_addr_o,
    output logic [DATA_W-1:0]   dbus_wdata_o,
    output logic [DATA_W/8-1:0] dbus_wstrb_o,
    input  logic                dbus_aready_i,
    input  logic [DATA_W-1:0]   dbus_rdata_i,
    input  logic                dbus_rvalid_i,
    output logic                err_o,
    input  logic                err_clr_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                state_q, state_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  instr_q, instr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  sel_aready;
    logic                  sel_rvalid;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  is_write;
    logic                  timeout;

    assign sel_aready = instr_q ? ibus_aready_i : dbus_aready_i;
    assign sel_rvalid = instr_q ? ibus_rvalid_i : dbus_rvalid_i;
    assign sel_rdata  = instr_q ? ibus_rdata_i  : dbus_rdata_i;
    assign is_write   = |wstrb_q;
    // The count crosses 2^TIMEOUT_W-1 during this cycle; >= also covers a REQ accept on that very cycle.
    assign timeout    = (cnt_q >= CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (cke_i) begin
            if (err_clr_i) begin
                err_d = 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (cpu_valid_i) begin
                        instr_d = cpu_instr_i;
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_wdata_i;
                        wstrb_d = cpu_instr_i ? '0 : cpu_wstrb_i;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_aready) begin
                        if (is_write) begin
                            rdata_d = '0;
                            state_d = DONE;
                        end else begin
                            state_d = RESP;
                        end
                    end else if (timeout) begin
                        rdata_d = is_write ? '0 : ERR_RDATA;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                RESP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_rvalid) begin
                        rdata_d = sel_rdata;
                        state_d = DONE;
                    end else if (timeout) begin
                        rdata_d = ERR_RDATA;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ibus_avalid_o = (state_q == REQ) && instr_q;
    assign dbus_avalid_o = (state_q == REQ) && !instr_q;
    assign ibus_addr_o   = addr_q;
    assign dbus_addr_o   = addr_q;
    assign dbus_wdata_o  = wdata_q;
    assign dbus_wstrb_o  = wstrb_q;
    assign cpu_rdata_o   = rdata_q;
    assign cpu_ready_o   = (state_q == DONE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_iob_cpu_bus_split.sv
// Self-checking bench for iob_cpu_bus_split with TIMEOUT_W=4 (timeout after 15 counted cycles).
// Expected completions are queued when a request is issued and popped when cpu_ready_o is seen.
module tb_iob_cpu_bus_split;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cke_i = 1'b1;
    logic        cpu_valid_i = 1'b0;
    logic        cpu_instr_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [31:0] cpu_wdata_i = '0;
    logic [3:0]  cpu_wstrb_i = '0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ready_o;
    logic        ibus_avalid_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_aready_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic        ibus_rvalid_i = 1'b0;
    logic        dbus_avalid_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_wstrb_o;
    logic        dbus_aready_i = 1'b0;
    logic [31:0] dbus_rdata_i = '0;
    logic        dbus_rvalid_i = 1'b0;
    logic        err_o;
    logic        err_clr_i = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    iob_cpu_bus_split #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT_W(4),
        .ERR_RDATA(32'hDEADBEEF)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cke_i        (cke_i),
        .cpu_valid_i  (cpu_valid_i),
        .cpu_instr_i  (cpu_instr_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_wstrb_i  (cpu_wstrb_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_ready_o  (cpu_ready_o),
        .ibus_avalid_o(ibus_avalid_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_aready_i(ibus_aready_i),
        .ibus_rdata_i (ibus_rdata_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .dbus_avalid_o(dbus_avalid_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_wstrb_o (dbus_wstrb_o),
        .dbus_aready_i(dbus_aready_i),
        .dbus_rdata_i (dbus_rdata_i),
        .dbus_rvalid_i(dbus_rvalid_i),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t mk(input logic [31:0] rdata, input int lat, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.lat   = lat;
        e.err   = err;
        return e;
    endfunction

    // Issues one request and plays the bus side: aready only in cycle ca, rvalid only in cycle cr
    // (0 = never), cycles counted from the edge that samples cpu_valid_i. lat = 0 means no completion.
    task automatic drive_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input int ca, input int cr, input logic [31:0] rd,
                             input int clrCycle, input logic stray, output int lat,
                             output logic [31:0] obsRdata, output int reqCycles,
                             output logic ibusSeen, output logic dbusSeen, output logic busBad);
        logic [3:0] effStrb;
        effStrb = instr ? 4'h0 : wstrb;
        lat = 0; obsRdata = '0; reqCycles = 0; ibusSeen = 1'b0; dbusSeen = 1'b0; busBad = 1'b0;
        cpu_valid_i = 1'b1; cpu_instr_i = instr; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_wstrb_i = wstrb;
        @(posedge clk_i); #1;
        cpu_valid_i = 1'b0;
        for (int c = 1; c <= 64 && lat == 0; c++) begin
            ibus_aready_i = instr && (c == ca);
            dbus_aready_i = !instr && (c == ca);
            ibus_rvalid_i = instr && (c == cr);
            ibus_rdata_i  = (instr && c == cr) ? rd : 32'h0BAD0BAD;
            dbus_rvalid_i = (!instr && c == cr) || (instr && stray);
            dbus_rdata_i  = (!instr && c == cr) ? rd : 32'hBADBAD00;
            err_clr_i     = (c == clrCycle);
            @(negedge clk_i);
            if (ibus_avalid_o === 1'b1) ibusSeen = 1'b1;
            if (dbus_avalid_o === 1'b1) dbusSeen = 1'b1;
            if (ibus_avalid_o === 1'b1 || dbus_avalid_o === 1'b1) begin
                reqCycles++;
                if (instr ? (ibus_addr_o !== addr)
                          : (dbus_addr_o !== addr || dbus_wdata_o !== wdata || dbus_wstrb_o !== effStrb))
                    busBad = 1'b1;
            end
            if (cpu_ready_o === 1'b1) begin
                lat = c;
                obsRdata = cpu_rdata_o;
            end
            @(posedge clk_i); #1;
        end
        ibus_aready_i = 1'b0; dbus_aready_i = 1'b0; ibus_rvalid_i = 1'b0; dbus_rvalid_i = 1'b0;
        ibus_rdata_i = '0; dbus_rdata_i = '0; err_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        vectors++; if (ibus_avalid_o !== 1'b0 || dbus_avalid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_avalid: got i=%b d=%b expected 0 0", ibus_avalid_o, dbus_avalid_o); end
        vectors++; if (cpu_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", cpu_ready_o); end
        vectors++; if (cpu_rdata_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", cpu_rdata_o); end
        vectors++; if (ibus_addr_o !== 32'h0 || dbus_addr_o !== 32'h0 || dbus_wdata_o !== 32'h0 || dbus_wstrb_o !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_bus_regs: got ia=%h da=%h wd=%h ws=%h expected all 0", ibus_addr_o, dbus_addr_o, dbus_wdata_o, dbus_wstrb_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        vectors++; if (cpu_ready_o !== 1'b0 || ibus_avalid_o !== 1'b0 || dbus_avalid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_idle: got rdy=%b i=%b d=%b expected 0 0 0", cpu_ready_o, ibus_avalid_o, dbus_avalid_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_instr_read();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'h00000013, 3, 1'b0));
        drive_req(1'b1, 32'h1000_0000, 32'h0, 4'h0, 1, 2, 32'h00000013, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL iread_latency: got %0d expected %0d", lat, e.lat); end
        vectors++; if (rd !== e.rdata) begin miscompares++; $display("[TB] FAIL iread_rdata: got %h expected %h", rd, e.rdata); end
        vectors++; if (iS !== 1'b1 || dS !== 1'b0 || rc !== 1) begin miscompares++; $display("[TB] FAIL iread_avalid: got ibus=%b dbus=%b cycles=%0d expected 1 0 1", iS, dS, rc); end
        vectors++; if (bb !== 1'b0) begin miscompares++; $display("[TB] FAIL iread_addr: got bad=%b expected 0", bb); end
        vectors++; if (err_o !== e.err) begin miscompares++; $display("[TB] FAIL iread_err: got %b expected %b", err_o, e.err); end
        @(negedge clk_i);
        vectors++; if (cpu_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL iread_ready_pulse: got %b expected 0", cpu_ready_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_data_write();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'h0, 4, 1'b0));
        drive_req(1'b0, 32'h80, 32'hA5A5A5A5, 4'hF, 3, 0, 32'h0, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL dwrite_latency: got %0d expected %0d", lat, e.lat); end
        vectors++; if (rd !== e.rdata) begin miscompares++; $display("[TB] FAIL dwrite_rdata: got %h expected %h", rd, e.rdata); end
        vectors++; if (iS !== 1'b0 || dS !== 1'b1 || rc !== 3) begin miscompares++; $display("[TB] FAIL dwrite_avalid: got ibus=%b dbus=%b cycles=%0d expected 0 1 3", iS, dS, rc); end
        vectors++; if (bb !== 1'b0) begin miscompares++; $display("[TB] FAIL dwrite_bus_stable: got bad=%b expected 0", bb); end
        @(negedge clk_i);
        vectors++; if (cpu_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL dwrite_ready_pulse: got %b expected 0", cpu_ready_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_instr_wstrb();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'h00100073, 3, 1'b0));
        drive_req(1'b1, 32'h1000_0008, 32'h55AA55AA, 4'hF, 1, 2, 32'h00100073, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat || rd !== e.rdata) begin miscompares++; $display("[TB] FAIL instr_wstrb_read: got lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, rd, e.lat, e.rdata); end
        vectors++; if (dbus_wstrb_o !== 4'h0) begin miscompares++; $display("[TB] FAIL instr_wstrb_forced: got %h expected 0", dbus_wstrb_o); end
    endtask

    task automatic test_stray_rvalid();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'h00500513, 4, 1'b0));
        drive_req(1'b1, 32'h1000_0010, 32'h0, 4'h0, 1, 3, 32'h00500513, 0, 1'b1, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL stray_latency: got %0d expected %0d", lat, e.lat); end
        vectors++; if (rd !== e.rdata) begin miscompares++; $display("[TB] FAIL stray_rdata: got %h expected %h", rd, e.rdata); end
    endtask

    task automatic test_back_to_back();
        logic        tInstr[3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] tAddr[3]  = '{32'h104, 32'h108, 32'h1000_0004};
        logic [31:0] tWdata[3] = '{32'h0, 32'h11223344, 32'h0};
        logic [3:0]  tStrb[3]  = '{4'h0, 4'h3, 4'h0};
        int          tCa[3]    = '{2, 1, 1};
        int          tCr[3]    = '{4, 0, 2};
        logic [31:0] tRd[3]    = '{32'hCAFEF00D, 32'h0, 32'h00000093};
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'hCAFEF00D, 5, 1'b0));
        sbq.push_back(mk(32'h0, 2, 1'b0));
        sbq.push_back(mk(32'h00000093, 3, 1'b0));
        for (int i = 0; i < 3; i++) begin
            drive_req(tInstr[i], tAddr[i], tWdata[i], tStrb[i], tCa[i], tCr[i], tRd[i], 0, 1'b0, lat, rd, rc, iS, dS, bb);
            e = sbq.pop_front();
            vectors++; if (lat !== e.lat || rd !== e.rdata || bb !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_%0d: got lat=%0d rdata=%h bad=%b expected lat=%0d rdata=%h bad=0", i, lat, rd, bb, e.lat, e.rdata); end
        end
    endtask

    task automatic test_cke();
        exp_t e; int readyCycles;
        sbq.push_back(mk(32'h12345678, 6, 1'b0));
        readyCycles = 0;
        cpu_valid_i = 1'b1; cpu_instr_i = 1'b0; cpu_addr_i = 32'h300; cpu_wstrb_i = 4'h0; dbus_aready_i = 1'b1;
        @(posedge clk_i); #1;
        cpu_valid_i = 1'b0;
        @(posedge clk_i); #1;
        dbus_aready_i = 1'b0; cke_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hBAD00BAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            vectors++; if (cpu_ready_o !== 1'b0 || dbus_avalid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cke_resp_hold_%0d: got rdy=%b avalid=%b expected 0 0", i, cpu_ready_o, dbus_avalid_o); end
            @(posedge clk_i); #1;
        end
        cke_i = 1'b1; dbus_rdata_i = 32'h12345678;
        @(posedge clk_i); #1;
        dbus_rvalid_i = 1'b0; dbus_rdata_i = '0; cke_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (cpu_ready_o === 1'b1) readyCycles++;
            @(posedge clk_i); #1;
        end
        cke_i = 1'b1;
        @(negedge clk_i);
        if (cpu_ready_o === 1'b1) readyCycles++;
        e = sbq.pop_front();
        vectors++; if (cpu_rdata_o !== e.rdata) begin miscompares++; $display("[TB] FAIL cke_rdata: got %h expected %h", cpu_rdata_o, e.rdata); end
        vectors++; if (readyCycles !== e.lat) begin miscompares++; $display("[TB] FAIL cke_ready_stretch: got %0d cycles expected %0d", readyCycles, e.lat); end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        vectors++; if (cpu_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cke_ready_end: got %b expected 0", cpu_ready_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_timeout_read();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'hDEADBEEF, 16, 1'b1));
        drive_req(1'b0, 32'h200, 32'h0, 4'h0, 0, 0, 32'h0, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (rc !== 15) begin miscompares++; $display("[TB] FAIL tmo_read_avalid_cycles: got %0d expected 15", rc); end
        vectors++; if (lat !== e.lat) begin miscompares++; $display("[TB] FAIL tmo_read_latency: got %0d expected %0d", lat, e.lat); end
        vectors++; if (rd !== e.rdata) begin miscompares++; $display("[TB] FAIL tmo_read_rdata: got %h expected %h", rd, e.rdata); end
        vectors++; if (err_o !== e.err) begin miscompares++; $display("[TB] FAIL tmo_read_err: got %b expected %b", err_o, e.err); end
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        @(negedge clk_i);
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL err_clear: got %b expected 0", err_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_timeout_write();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'h0, 16, 1'b1));
        drive_req(1'b0, 32'h204, 32'h99887766, 4'h3, 0, 0, 32'h0, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat || rd !== e.rdata) begin miscompares++; $display("[TB] FAIL tmo_write: got lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, rd, e.lat, e.rdata); end
        vectors++; if (err_o !== e.err) begin miscompares++; $display("[TB] FAIL tmo_write_err: got %b expected %b", err_o, e.err); end
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
    endtask

    task automatic test_handshake_at_timeout();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'h0F0F1234, 16, 1'b0));
        sbq.push_back(mk(32'h0, 16, 1'b0));
        drive_req(1'b0, 32'h208, 32'h0, 4'h0, 1, 15, 32'h0F0F1234, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat || rd !== e.rdata || err_o !== e.err) begin miscompares++; $display("[TB] FAIL rvalid_at_timeout: got lat=%0d rdata=%h err=%b expected lat=%0d rdata=%h err=%b", lat, rd, err_o, e.lat, e.rdata, e.err); end
        drive_req(1'b0, 32'h20C, 32'h76543210, 4'hF, 15, 0, 32'h0, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat || rd !== e.rdata || err_o !== e.err) begin miscompares++; $display("[TB] FAIL aready_at_timeout: got lat=%0d rdata=%h err=%b expected lat=%0d rdata=%h err=%b", lat, rd, err_o, e.lat, e.rdata, e.err); end
    endtask

    task automatic test_clr_vs_timeout();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        sbq.push_back(mk(32'hDEADBEEF, 16, 1'b1));
        drive_req(1'b1, 32'h1000_0020, 32'h0, 4'h0, 0, 0, 32'h0, 15, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat || rd !== e.rdata) begin miscompares++; $display("[TB] FAIL clr_vs_tmo_resp: got lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, rd, e.lat, e.rdata); end
        vectors++; if (err_o !== e.err) begin miscompares++; $display("[TB] FAIL clr_vs_tmo_err: got %b expected %b", err_o, e.err); end
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat, rc; logic [31:0] rd; logic iS, dS, bb;
        cpu_valid_i = 1'b1; cpu_instr_i = 1'b1; cpu_addr_i = 32'h1000_0400; cpu_wstrb_i = 4'h0; ibus_aready_i = 1'b1;
        @(posedge clk_i); #1;
        cpu_valid_i = 1'b0;
        @(posedge clk_i); #1;
        ibus_aready_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        vectors++; if (ibus_avalid_o !== 1'b0 || dbus_avalid_o !== 1'b0 || cpu_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_outputs: got i=%b d=%b rdy=%b expected 0 0 0", ibus_avalid_o, dbus_avalid_o, cpu_ready_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_err: got %b expected 0", err_o); end
        @(posedge clk_i); #1;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0BAD0;
        rst_i = 1'b0;
        @(negedge clk_i);
        ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
        vectors++; if (cpu_ready_o !== 1'b0 || ibus_avalid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_idle: got rdy=%b i=%b expected 0 0", cpu_ready_o, ibus_avalid_o); end
        @(posedge clk_i); #1;
        sbq.push_back(mk(32'h00000037, 3, 1'b0));
        drive_req(1'b1, 32'h1000_0404, 32'h0, 4'h0, 1, 2, 32'h00000037, 0, 1'b0, lat, rd, rc, iS, dS, bb);
        e = sbq.pop_front();
        vectors++; if (lat !== e.lat || rd !== e.rdata) begin miscompares++; $display("[TB] FAIL rst_mid_recover: got lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, rd, e.lat, e.rdata); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_instr_read();
        test_data_write();
        test_instr_wstrb();
        test_stray_rvalid();
        test_back_to_back();
        test_cke();
        test_timeout_read();
        test_timeout_write();
        test_handshake_at_timeout();
        test_clr_vs_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iob_cpu_bus_split.md
# iob_cpu_bus_split

Parametrised bridge between a single PicoRV32-style valid/ready memory port and two IOb native buses: instruction (read-only) and data. Each CPU request is registered, presented on the bus selected by the instruction flag with a proper avalid/aready handshake, and completed by tracking the read response or generating a write acknowledge. A per-request response timeout terminates hung transactions and raises a sticky error. The block sits between the CPU core and the system interconnect in the CPU wrapper.

## Interface
- ADDR_W, 32, address width, both buses
- DATA_W, 32, data width; wstrb width is DATA_W/8
- TIMEOUT_W, 8, timeout counter width (2 to 16); timeout at 2^TIMEOUT_W-1 cycles
- ERR_RDATA, 32'hDEADBEEF (DATA_W bits), read data returned on timeout

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cke_i  in  1  clock enable; low freezes all state
- cpu_valid_i  in  1  CPU request valid
- cpu_instr_i  in  1  1 = instruction fetch
- cpu_addr_i  in  ADDR_W  request address
- cpu_wdata_i  in  DATA_W  write data
- cpu_wstrb_i  in  DATA_W/8  byte strobes; 0 = read
- cpu_rdata_o  out  DATA_W  response data
- cpu_ready_o  out  1  one-cycle completion pulse
- ibus_avalid_o  out  1  instruction request valid
- ibus_addr_o  out  ADDR_W  instruction address
- ibus_aready_i  in  1  instruction request accepted
- ibus_rdata_i  in  DATA_W  instruction read data
- ibus_rvalid_i  in  1  instruction read data valid
- dbus_avalid_o  out  1  data request valid
- dbus_addr_o  out  ADDR_W  data address
- dbus_wdata_o  out  DATA_W  write data
- dbus_wstrb_o  out  DATA_W/8  byte strobes
- dbus_aready_i  in  1  data request accepted
- dbus_rdata_i  in  DATA_W  data read data
- dbus_rvalid_i  in  1  data read data valid
- err_o  out  1  sticky timeout flag
- err_clr_i  in  1  clears err_o

## Operation
- FSM states IDLE, REQ, RESP, DONE. All transitions and counter updates require cke_i=1.
- IDLE: on cpu_valid_i=1, register instr, addr, wdata and wstrb. Registered wstrb is forced to 0 when instr=1 (ibus is read-only). Clear the timeout counter and go to REQ.
- REQ: assert avalid on the selected bus only, driven from registers; the other bus's avalid stays 0. When the selected aready=1: go to DONE if wstrb≠0 (write acknowledge, cpu_rdata_o=0), otherwise go to RESP. rvalid is ignored in REQ.
- RESP: avalid=0. When the selected rvalid=1, register its rdata into cpu_rdata_o and go to DONE.
- DONE: cpu_ready_o=1 for exactly one cycle, then go to IDLE. cpu_valid_i is not sampled in DONE.
- Timeout: the counter increments each cke cycle in REQ and RESP. When it reaches 2^TIMEOUT_W-1 with no acceptance or response:
  - avalid drops;
  - a read loads ERR_RDATA, a write loads 0;
  - err_o is set and the FSM goes to DONE.
- If the completing handshake and the timeout occur in the same cycle, the handshake wins and no error is raised.
- err_o: set by timeout, cleared by err_clr_i. If both occur in the same cycle, set wins.
- rvalid on either bus outside RESP, or on the unselected bus, is ignored.
- Bus addr, wdata and wstrb outputs hold their registered values outside REQ.

## Timing
- Reset values:
  - state = IDLE
  - all avalid outputs = 0
  - cpu_ready_o = 0
  - cpu_rdata_o = 0
  - addr, wdata and wstrb outputs = 0
  - err_o = 0
  - counter = 0
- Reset asserted mid-transaction returns the block to IDLE immediately and asynchronously; the outstanding response is dropped.
- Read with aready=1 at the first REQ cycle and rvalid one cycle later: cpu_valid_i sampled at edge 0, avalid high in cycle 1, RESP in cycle 2, cpu_ready_o in cycle 3.
- Write with immediate aready: cpu_ready_o in cycle 2.
- Each extra wait cycle on aready or rvalid adds exactly one cycle.
- Requests are strictly serialised; at most one is outstanding.
- With cke_i=0 the state, counter and all outputs hold, including a cpu_ready_o pulse, which is stretched.

## Test plan
- Instruction read: valid, instr=1, addr=0x10000000; aready=1, rvalid next cycle with rdata=0x00000013 → only ibus_avalid_o rises, cpu_rdata_o=0x00000013, cpu_ready_o for one cycle, 3 cycles after valid.
- Data write: addr=0x80, wdata=0xA5A5A5A5, wstrb=0xF; aready delayed 2 cycles → dbus outputs stable while waiting, cpu_ready_o 4 cycles after valid, cpu_rdata_o=0, ibus_avalid_o never rises.
- Read timeout with TIMEOUT_W=4: aready held 0 → avalid drops after 15 REQ cycles, cpu_rdata_o=0xDEADBEEF, err_o=1; later err_clr_i pulse → err_o=0.
- Simultaneous events: rvalid in the final timeout cycle → real data returned, err_o stays 0; err_clr_i coinciding with a timeout → err_o=1.
- Clock enable: cke_i=0 for 5 cycles during RESP and during DONE → no state change, cpu_ready_o stretched, completes correctly afterwards.
- Robustness: rst_i pulsed in RESP → avalid outputs and cpu_ready_o 0 immediately, IDLE after release. A stray dbus_rvalid_i during an ibus read is ignored.
